// File: rtl/iic_arb_pkg.sv
// Shared definitions for the IIC_MAIN two-master arbiter: state encoding,
// idle bus levels and the recovery sequence length.
package iic_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_BUF,
        ST_RECOVER
    } arb_state_t;

    localparam logic IDLE_SCL  = 1'b1;
    localparam logic IDLE_SDA  = 1'b0;
    localparam logic IDLE_SDAT = 1'b1;

    // 9 clock pulses (two half periods each) followed by the 3 STOP half periods
    localparam int RECOVER_PULSES = 9;
    localparam int RECOVER_PHASES = 2 * RECOVER_PULSES + 3;

    function automatic int cyc_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/iic_bus_recover.sv
// Bus recovery generator: 9 SCL pulses with SDA released, then a STOP,
// every level held for HALF_CYC clocks. busy stays high for 21*HALF_CYC clocks.
module iic_bus_recover
    import iic_arb_pkg::*;
#(
    parameter int HALF_CYC = 625
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic scl,
    output logic sda,
    output logic sdat
);

    localparam int HW = cyc_width(HALF_CYC);
    localparam int PW = cyc_width(RECOVER_PHASES);

    logic [HW-1:0] half_cnt;
    logic [PW-1:0] phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= 1'b0;
            half_cnt <= '0;
            phase    <= '0;
        end else if (!busy) begin
            half_cnt <= '0;
            phase    <= '0;
            if (start)
                busy <= 1'b1;
        end else if (half_cnt == HW'(HALF_CYC - 1)) begin
            half_cnt <= '0;
            if (phase == PW'(RECOVER_PHASES - 1))
                busy <= 1'b0;
            else
                phase <= phase + 1'b1;
        end else begin
            half_cnt <= half_cnt + 1'b1;
        end
    end

    // even phases drive SCL low, odd phases high; the last three form the STOP
    always_comb begin
        scl  = IDLE_SCL;
        sda  = IDLE_SDA;
        sdat = IDLE_SDAT;
        if (busy) begin
            if (phase < PW'(2 * RECOVER_PULSES)) begin
                scl = phase[0];
            end else if (phase == PW'(2 * RECOVER_PULSES)) begin
                scl  = 1'b0;
                sdat = 1'b0;
            end else if (phase == PW'(2 * RECOVER_PULSES + 1)) begin
                sdat = 1'b0;
            end
        end
    end

endmodule

// File: rtl/iic_main_arbiter.sv
// Round-robin owner arbitration of the IIC_MAIN bus between two I2C masters,
// with a bus-free gap between owners and a watchdog that revokes and recovers.
module iic_main_arbiter
    import iic_arb_pkg::*;
#(
    parameter int SYSCLK_FREQ_IN_MHz = 125,
    parameter int BUF_TIME_US        = 5,
    parameter int TIMEOUT_MS         = 10,
    parameter int RECOVER_KHZ        = 100
) (
    input  logic       SYSCLK_IN,
    input  logic       RESET_IN,
    input  logic [1:0] REQ_IN,
    output logic [1:0] GNT_OUT,
    input  logic [1:0] REQ_SCL_IN,
    input  logic [1:0] REQ_SDA_IN,
    input  logic [1:0] REQ_SDAT_IN,
    output logic [1:0] REQ_SDA_OUT,
    output logic       SCL_OUT,
    output logic       SDA_OUT,
    output logic       SDAT_OUT,
    input  logic       SDA_IN,
    output logic       TIMEOUT_OUT,
    output logic       RECOVERING_OUT
);

    localparam int BUF_CYC  = SYSCLK_FREQ_IN_MHz * BUF_TIME_US;
    localparam int TO_CYC   = SYSCLK_FREQ_IN_MHz * 1000 * TIMEOUT_MS;
    localparam int HALF_CYC = SYSCLK_FREQ_IN_MHz * 500 / RECOVER_KHZ;
    localparam int BW       = cyc_width(BUF_CYC);
    localparam int TW       = cyc_width(TO_CYC);

    arb_state_t    state, state_nxt;
    logic [1:0]    gnt_q, elig, req_mask;
    logic          owner, rr_ptr, winner, rel, to_hit, timeout_q;
    logic [TW-1:0] hold_cnt;
    logic [BW-1:0] buf_cnt;
    logic          rec_start, rec_busy, rec_scl, rec_sda, rec_sdat;

    iic_bus_recover #(.HALF_CYC(HALF_CYC)) u_recover (
        .clk   (SYSCLK_IN),
        .rst   (RESET_IN),
        .start (rec_start),
        .busy  (rec_busy),
        .scl   (rec_scl),
        .sda   (rec_sda),
        .sdat  (rec_sdat)
    );

    always_ff @(posedge SYSCLK_IN or posedge RESET_IN) begin
        if (RESET_IN)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // a revoked owner stays masked until its REQ has been seen low once
    always_comb begin
        elig      = REQ_IN & ~req_mask;
        winner    = (elig == 2'b11) ? rr_ptr : elig[1];
        rel       = !REQ_IN[owner];
        to_hit    = (hold_cnt == TW'(TO_CYC - 1));
        rec_start = (state == ST_GRANT) && !rel && to_hit;
        state_nxt = state;
        case (state)
            ST_IDLE:    if (|elig) state_nxt = ST_GRANT;
            ST_GRANT:   if (rel) state_nxt = ST_BUF;
                        else if (to_hit) state_nxt = ST_RECOVER;
            ST_BUF:     if (buf_cnt == BW'(BUF_CYC - 1)) state_nxt = ST_IDLE;
            ST_RECOVER: if (!rec_busy) state_nxt = ST_BUF;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge SYSCLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            gnt_q     <= 2'b00;
            owner     <= 1'b0;
            rr_ptr    <= 1'b0;
            req_mask  <= 2'b00;
            timeout_q <= 1'b0;
            hold_cnt  <= '0;
            buf_cnt   <= '0;
        end else begin
            req_mask  <= (req_mask & REQ_IN) | (rec_start ? (owner ? 2'b10 : 2'b01) : 2'b00);
            timeout_q <= rec_start;
            hold_cnt  <= (state == ST_GRANT) ? hold_cnt + 1'b1 : '0;
            buf_cnt   <= (state == ST_BUF) ? buf_cnt + 1'b1 : '0;
            if (state == ST_IDLE && |elig) begin
                gnt_q <= winner ? 2'b10 : 2'b01;
                owner <= winner;
            end else if (state == ST_GRANT && (rel || to_hit)) begin
                gnt_q  <= 2'b00;
                rr_ptr <= ~owner;
            end
        end
    end

    always_comb begin
        REQ_SDA_OUT    = {2{SDA_IN}};
        GNT_OUT        = gnt_q;
        TIMEOUT_OUT    = timeout_q;
        RECOVERING_OUT = rec_busy;
        SCL_OUT        = IDLE_SCL;
        SDA_OUT        = IDLE_SDA;
        SDAT_OUT       = IDLE_SDAT;
        case (state)
            ST_GRANT: begin
                SCL_OUT  = REQ_SCL_IN[owner];
                SDA_OUT  = REQ_SDA_IN[owner];
                SDAT_OUT = REQ_SDAT_IN[owner];
            end
            ST_RECOVER: begin
                SCL_OUT  = rec_scl;
                SDA_OUT  = rec_sda;
                SDAT_OUT = rec_sdat;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_iic_main_arbiter.sv
// Scoreboard bench for iic_main_arbiter: stimulus predicts grant/drop/timeout/
// recovery events from the arbitration rules; a monitor matches DUT events.
module tb_iic_main_arbiter;

    localparam int P_MHZ    = 1;
    localparam int P_BUF_US = 20;
    localparam int P_TO_MS  = 1;
    localparam int P_KHZ    = 25;
    localparam int BUF_CYC  = P_MHZ * P_BUF_US;
    localparam int TO_CYC   = P_MHZ * 1000 * P_TO_MS;
    localparam int HALF     = P_MHZ * 500 / P_KHZ;

    localparam int EV_GNT  = 0;
    localparam int EV_DROP = 1;
    localparam int EV_TO   = 2;
    localparam int EV_REC  = 3;

    typedef struct {
        int         kind;
        logic [1:0] vec;
        int         at;
    } ev_t;

    logic       SYSCLK_IN = 1'b0;
    logic       RESET_IN;
    logic [1:0] REQ_IN, GNT_OUT, REQ_SCL_IN, REQ_SDA_IN, REQ_SDAT_IN, REQ_SDA_OUT;
    logic       SCL_OUT, SDA_OUT, SDAT_OUT, SDA_IN, TIMEOUT_OUT, RECOVERING_OUT;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   mon_en = 1'b0;
    ev_t  expq[$];
    int   avail = 0;
    int   pref = 0;

    iic_main_arbiter #(
        .SYSCLK_FREQ_IN_MHz (P_MHZ),
        .BUF_TIME_US        (P_BUF_US),
        .TIMEOUT_MS         (P_TO_MS),
        .RECOVER_KHZ        (P_KHZ)
    ) dut (
        .SYSCLK_IN      (SYSCLK_IN),
        .RESET_IN       (RESET_IN),
        .REQ_IN         (REQ_IN),
        .GNT_OUT        (GNT_OUT),
        .REQ_SCL_IN     (REQ_SCL_IN),
        .REQ_SDA_IN     (REQ_SDA_IN),
        .REQ_SDAT_IN    (REQ_SDAT_IN),
        .REQ_SDA_OUT    (REQ_SDA_OUT),
        .SCL_OUT        (SCL_OUT),
        .SDA_OUT        (SDA_OUT),
        .SDAT_OUT       (SDAT_OUT),
        .SDA_IN         (SDA_IN),
        .TIMEOUT_OUT    (TIMEOUT_OUT),
        .RECOVERING_OUT (RECOVERING_OUT)
    );

    always #5 SYSCLK_IN = ~SYSCLK_IN;
    always @(posedge SYSCLK_IN) cyc <= cyc + 1;

    task automatic tick();
        @(posedge SYSCLK_IN);
        #1;
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) tick();
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [1:0] onehot(input int i);
        return (i == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic exp_ev(input int kind, input logic [1:0] vec, input int at);
        ev_t e;
        e.kind = kind;
        e.vec  = vec;
        e.at   = at;
        expq.push_back(e);
    endtask

    task automatic pop_cmp(input int kind, input logic [1:0] vec);
        ev_t e;
        total++;
        if (expq.size() == 0) begin
            bad++;
            $display("FAIL event: unexpected kind=%0d gnt=%b at cyc %0d", kind, vec, cyc);
        end else begin
            e = expq.pop_front();
            if (e.kind != kind || e.vec != vec || e.at != cyc) begin
                bad++;
                $display("FAIL event: got kind=%0d gnt=%b cyc=%0d want kind=%0d gnt=%b cyc=%0d",
                         kind, vec, cyc, e.kind, e.vec, e.at);
            end
        end
    endtask

    // monitor: every grant edge, drop, timeout pulse and end of recovery
    initial begin
        logic [1:0] prev_gnt;
        logic       prev_rec;
        prev_gnt = 2'b00;
        prev_rec = 1'b0;
        forever begin
            @(negedge SYSCLK_IN);
            if (mon_en) begin
                if (GNT_OUT != prev_gnt) begin
                    if (prev_gnt != 2'b00) pop_cmp(EV_DROP, prev_gnt);
                    if (GNT_OUT != 2'b00) pop_cmp(EV_GNT, GNT_OUT);
                end
                if (TIMEOUT_OUT) pop_cmp(EV_TO, 2'b00);
                if (prev_rec && !RECOVERING_OUT) pop_cmp(EV_REC, 2'b00);
            end
            prev_gnt = GNT_OUT;
            prev_rec = RECOVERING_OUT;
        end
    end

    // reference model: grant no earlier than the bus becomes available,
    // contested grants go to the requester not served last
    task automatic run_txn(input logic [1:0] pat, input int gap, input int l1,
                           input int l2, input bit wiggle);
        int t, g1, g2, w, o;
        repeat (gap) tick();
        t = cyc;
        REQ_IN = REQ_IN | pat;
        w = (pat == 2'b11) ? pref : (pat[1] ? 1 : 0);
        o = 1 - w;
        g1 = (t + 1 > avail) ? t + 1 : avail;
        g2 = g1 + l1 + 2 + BUF_CYC;
        exp_ev(EV_GNT, onehot(w), g1);
        exp_ev(EV_DROP, onehot(w), g1 + l1 + 1);
        if (pat == 2'b11) begin
            exp_ev(EV_GNT, onehot(o), g2);
            exp_ev(EV_DROP, onehot(o), g2 + l2 + 1);
        end
        wait_until(g1);
        if (wiggle) begin
            for (int i = 0; i < 6; i++) begin
                REQ_SCL_IN  = (i == 0) ? (w == 1 ? 2'b01 : 2'b10) : 2'($urandom);
                REQ_SDA_IN  = 2'($urandom);
                REQ_SDAT_IN = 2'($urandom);
                #1;
                check("bus_mux", {SCL_OUT, SDA_OUT, SDAT_OUT},
                      {REQ_SCL_IN[w], REQ_SDA_IN[w], REQ_SDAT_IN[w]});
            end
            REQ_SCL_IN  = 2'b11;
            REQ_SDA_IN  = 2'b00;
            REQ_SDAT_IN = 2'b11;
        end
        wait_until(g1 + l1);
        REQ_IN[w] = 1'b0;
        pref  = o;
        avail = g1 + l1 + 2 + BUF_CYC;
        if (pat == 2'b11) begin
            wait_until(g2 + l2);
            REQ_IN[o] = 1'b0;
            pref  = w;
            avail = g2 + l2 + 2 + BUF_CYC;
        end
    endtask

    initial begin
        int r, g, t, gap_bad, nf, pace_bad, stop_at;
        logic p_scl, p_sdat;
        logic [1:0] pat;

        RESET_IN    = 1'b1;
        REQ_IN      = 2'b00;
        REQ_SCL_IN  = 2'b11;
        REQ_SDA_IN  = 2'b00;
        REQ_SDAT_IN = 2'b11;
        SDA_IN      = 1'b1;
        repeat (3) tick();
        check("rst_gnt", GNT_OUT, 0);
        check("rst_scl", SCL_OUT, 1);
        check("rst_sda", SDA_OUT, 0);
        check("rst_sdat", SDAT_OUT, 1);
        check("rst_to", TIMEOUT_OUT, 0);
        check("rst_rec", RECOVERING_OUT, 0);
        SDA_IN = 1'b0;
        #1 check("sda_fanout0", REQ_SDA_OUT, 0);
        SDA_IN = 1'b1;
        #1 check("sda_fanout1", REQ_SDA_OUT, 3);
        tick();
        RESET_IN = 1'b0;
        mon_en   = 1'b1;

        // simultaneous requests out of reset: requester 0 first
        run_txn(2'b11, 1, 5, 6, 1'b1);

        // bus-free gap with both masters pulling their lines low while unowned
        run_txn(2'b01, 1, 4, 0, 1'b0);
        r = cyc;
        REQ_SCL_IN  = 2'b00;
        REQ_SDAT_IN = 2'b00;
        gap_bad = 0;
        tick();
        while (cyc < avail) begin
            if (cyc == r + 10) begin
                REQ_IN[0] = 1'b1;
                exp_ev(EV_GNT, 2'b01, avail);
            end
            if (SCL_OUT !== 1'b1 || SDAT_OUT !== 1'b1) gap_bad++;
            tick();
        end
        check("gap_idle", gap_bad, 0);
        REQ_SCL_IN  = 2'b11;
        REQ_SDAT_IN = 2'b11;
        tick();
        REQ_IN[0] = 1'b0;
        exp_ev(EV_DROP, 2'b01, cyc + 1);
        pref  = 1;
        avail = cyc + 2 + BUF_CYC;

        // release in the very cycle the watchdog would fire: no timeout
        run_txn(2'b01, 1, TO_CYC - 1, 0, 1'b0);

        // requester 1 holds its grant past the watchdog
        tick();
        t = cyc;
        REQ_IN[1] = 1'b1;
        g = (t + 1 > avail) ? t + 1 : avail;
        exp_ev(EV_GNT, 2'b10, g);
        exp_ev(EV_DROP, 2'b10, g + TO_CYC);
        exp_ev(EV_TO, 2'b00, g + TO_CYC);
        exp_ev(EV_REC, 2'b00, g + TO_CYC + 21 * HALF);
        wait_until(g + TO_CYC - 1);
        p_scl = SCL_OUT;
        p_sdat = SDAT_OUT;
        nf = 0;
        pace_bad = 0;
        stop_at = -1;
        while (cyc < g + TO_CYC + 21 * HALF) begin
            tick();
            if (p_scl && !SCL_OUT && SDAT_OUT) begin
                if (cyc != g + TO_CYC + 2 * nf * HALF) pace_bad++;
                nf++;
            end
            if (!p_sdat && SDAT_OUT && SCL_OUT) stop_at = cyc;
            p_scl = SCL_OUT;
            p_sdat = SDAT_OUT;
        end
        check("rec_falls", nf, 9);
        check("rec_pace", pace_bad, 0);
        check("rec_stop", stop_at, g + TO_CYC + 20 * HALF);
        avail = g + TO_CYC + 21 * HALF + 2 + BUF_CYC;
        pref  = 0;

        // revoked requester keeps REQ high: others served, it stays masked
        run_txn(2'b01, 1, 5, 0, 1'b0);
        repeat (BUF_CYC + 20) tick();
        check("masked_gnt", GNT_OUT, 0);
        REQ_IN[1] = 1'b0;
        tick();
        run_txn(2'b10, 0, 3, 0, 1'b0);

        for (int k = 0; k < 25; k++) begin
            pat = 2'($urandom_range(1, 3));
            run_txn(pat, $urandom_range(1, 30), $urandom_range(0, 40),
                    $urandom_range(0, 40), k < 3);
        end

        // asynchronous reset while requester 0 holds SCL low
        tick();
        t = cyc;
        REQ_IN = 2'b01;
        g = (t + 1 > avail) ? t + 1 : avail;
        exp_ev(EV_GNT, 2'b01, g);
        wait_until(g + 2);
        REQ_SCL_IN  = 2'b10;
        REQ_SDAT_IN = 2'b10;
        #1 check("pre_rst_scl", SCL_OUT, 0);
        mon_en   = 1'b0;
        RESET_IN = 1'b1;
        #1;
        check("async_rst_scl", SCL_OUT, 1);
        check("async_rst_sdat", SDAT_OUT, 1);
        check("async_rst_gnt", GNT_OUT, 0);
        REQ_IN      = 2'b00;
        REQ_SCL_IN  = 2'b11;
        REQ_SDAT_IN = 2'b11;
        tick();
        RESET_IN = 1'b0;
        tick();

        check("queue_empty", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        bad++;
        $display("FAIL watchdog: run did not end by cyc %0d", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
